// File: rtl/addern_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
// ADDERN_PIPE_CARRY_VEC_EN selects whether the full per-bit carry vector is carried down the pipe.
package addern_pipe_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

`ifdef ADDERN_PIPE_CARRY_VEC_EN
    localparam bit CARRY_VEC_EN = 1'b1;
`else
    localparam bit CARRY_VEC_EN = 1'b0;
`endif

    function automatic int stages_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Without the full vector only the top two carries survive: [1] = bit WIDTH-1, [0] = bit WIDTH-2.
    function automatic int cv_width(input int width);
        return CARRY_VEC_EN ? width : 2;
    endfunction

endpackage

// File: rtl/addern_pipe_circuit_add_chunk_stage.sv
// One CHUNK-bit ripple slice and its pipeline register; all stages advance together on adv.
// ADDERN_PIPE_CARRY_VEC_EN selects full carry-vector storage versus the top two carries only.
module add_chunk_stage
    import addern_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0,
    parameter int CVW   = 2
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              adv,
    input  stage_ctrl_t       prev_ctrl,
    input  logic [WIDTH-1:0]  prev_a,
    input  logic [WIDTH-1:0]  prev_b,
    input  logic [WIDTH-1:0]  prev_sum,
    input  logic [CVW-1:0]    prev_cv,
    output stage_ctrl_t       ctrl_q,
    output logic [WIDTH-1:0]  a_q,
    output logic [WIDTH-1:0]  b_q,
    output logic [WIDTH-1:0]  sum_q,
    output logic [CVW-1:0]    cv_q
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]    rip;
    logic [CHUNK-1:0]  s_slice;
    logic [WIDTH-1:0]  sum_nx;
    logic [CVW-1:0]    cv_nx;

    assign rip[0] = prev_ctrl.carry;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fadd_circuit u_fa (
            .a    (prev_a[LO+i]),
            .b    (prev_b[LO+i]),
            .cin  (rip[i]),
            .s    (s_slice[i]),
            .cout (rip[i+1])
        );
    end

    always_comb begin
        sum_nx = prev_sum;
        sum_nx[LO +: CHUNK] = s_slice;
        cv_nx = prev_cv;
`ifdef ADDERN_PIPE_CARRY_VEC_EN
        cv_nx[LO +: CHUNK] = rip[CHUNK:1];
`else
        for (int i = 0; i < CHUNK; i++) begin
            if (LO + i == WIDTH - 1) cv_nx[1] = rip[i+1];
            if (LO + i == WIDTH - 2) cv_nx[0] = rip[i+1];
        end
`endif
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cv_q   <= '0;
        end else if (adv) begin
            ctrl_q <= '{valid: prev_ctrl.valid, carry: rip[CHUNK]};
            a_q    <= prev_a;
            b_q    <= prev_b;
            sum_q  <= sum_nx;
            cv_q   <= cv_nx;
        end
    end

endmodule

// File: rtl/fadd_circuit.sv
// Single-bit full adder cell.
module fadd_circuit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addern_pipe_circuit.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage, valid/ready on both sides.
// ADDERN_PIPE_CARRY_VEC_EN: when defined, cout is the full per-bit carry vector; otherwise only cout[WIDTH-1].
//
// Handshake: a beat is accepted when in_valid && in_ready, a result leaves when out_valid && out_ready;
// in_ready = !out_valid || out_ready, so the whole pipe (bubbles included) shifts or freezes as one.
module addern_pipe_circuit
    import addern_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  sum,
    output logic [WIDTH-1:0]  cout,
    output logic              ovf
);

    localparam int STAGES = stages_of(WIDTH, CHUNK);
    localparam int CVW    = cv_width(WIDTH);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_bad
        $error("addern_pipe_circuit: WIDTH must be a positive multiple of CHUNK");
    end

    // Element 0 is the input side; element k+1 is the register of stage k.
    stage_ctrl_t       ctrl_st [STAGES+1];
    logic [WIDTH-1:0]  a_st    [STAGES+1];
    logic [WIDTH-1:0]  b_st    [STAGES+1];
    logic [WIDTH-1:0]  sum_st  [STAGES+1];
    logic [CVW-1:0]    cv_st   [STAGES+1];
    logic              adv;
    logic              unused_tail;

    assign out_valid = ctrl_st[STAGES].valid;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    assign ctrl_st[0] = '{valid: in_valid, carry: cin ^ sub};
    assign a_st[0]    = a;
    assign b_st[0]    = b ^ {WIDTH{sub}};
    assign sum_st[0]  = '0;
    assign cv_st[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k),
            .CVW   (CVW)
        ) u_stage (
            .clk       (clk),
            .aresetn   (aresetn),
            .adv       (adv),
            .prev_ctrl (ctrl_st[k]),
            .prev_a    (a_st[k]),
            .prev_b    (b_st[k]),
            .prev_sum  (sum_st[k]),
            .prev_cv   (cv_st[k]),
            .ctrl_q    (ctrl_st[k+1]),
            .a_q       (a_st[k+1]),
            .b_q       (b_st[k+1]),
            .sum_q     (sum_st[k+1]),
            .cv_q      (cv_st[k+1])
        );
    end

    assign sum = sum_st[STAGES];

`ifdef ADDERN_PIPE_CARRY_VEC_EN
    assign cout = cv_st[STAGES];
    if (WIDTH >= 2) begin : g_ovf
        assign ovf = cv_st[STAGES][WIDTH-1] ^ cv_st[STAGES][WIDTH-2];
    end else begin : g_no_ovf
        assign ovf = 1'b0;
    end
`else
    if (WIDTH >= 2) begin : g_ovf
        assign cout = {cv_st[STAGES][1], {(WIDTH-1){1'b0}}};
        assign ovf  = cv_st[STAGES][1] ^ cv_st[STAGES][0];
    end else begin : g_no_ovf
        assign cout = cv_st[STAGES][1];
        assign ovf  = 1'b0;
    end
`endif

    // The last stage's operand copies and carry have no consumer.
    assign unused_tail = ^{a_st[STAGES], b_st[STAGES], ctrl_st[STAGES].carry, cv_st[STAGES][0]};

endmodule
